// File: rtl/manch_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manch_rx_pkg
//  Description : Shared types and helpers for the Manchester-receive to MII
//                framer. It holds the framer state encoding, the SFD byte
//                value and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package manch_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DROP     = 3'd2,
    DATA     = 3'd3,
    FLUSH    = 3'd4
  } rx_state_t;

  localparam logic [7:0] SFD_BYTE = 8'hD5;

  // Returns the number of bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val < 2) w = 1;
    else             w = $clog2(max_val + 1);
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/manch_rx_mii_framer_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : mii_rx_clkgen
//  Description : Nibble-phase counter for the MII receive side. It produces
//                mii_rx_clk and the nibble update event (NU).
//  Revision    : 1.0 - initial release
//  Ports       : clk       - 16x bit clock
//                rst       - synchronous active-high reset
//                sync_zero - forces the phase counter to 0 on the next edge
//                use_sync  - NU follows sync_zero (data phase) instead of wrap
//                rx_clk    - registered nibble clock, high in upper half phase
//                nu        - nibble update event (combinational)
// ============================================================================
module mii_rx_clkgen
  import manch_rx_pkg::*;
#(
  parameter int unsigned BIT_CLKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_zero,
  input  logic use_sync,
  output logic rx_clk,
  output logic nu
);

  localparam int unsigned NIB_CLKS = 4 * BIT_CLKS;
  localparam int unsigned PHW      = cnt_width(NIB_CLKS - 1);

  logic [PHW-1:0] ph;
  logic [PHW-1:0] ph_n;
  logic           wrap;

  assign wrap = (ph == PHW'(NIB_CLKS - 1));
  assign nu   = use_sync ? sync_zero : wrap;

  always_comb begin
    ph_n = ph + PHW'(1);
    if (sync_zero || wrap) ph_n = '0;
  end

  // rx_clk is registered from the next phase value so it always equals
  // (ph >= half period); a forced sync therefore produces the falling edge
  // on the same edge that the nibble outputs change.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph     <= '0;
      rx_clk <= 1'b0;
    end else begin
      ph     <= ph_n;
      rx_clk <= (ph_n >= PHW'(2 * BIT_CLKS));
    end
  end

endmodule
`default_nettype wire

// File: rtl/manch_rx_mii_framer.sv
`default_nettype none
// ============================================================================
//  Module      : manch_rx_mii_framer
//  Description : Hunts the preamble and SFD in a decoded NRZ bit stream, packs
//                bits LSB-first into nibbles and drives an MII receive port.
//                Flags SFD timeouts, oversize frames and partial final bytes.
//  Revision    : 1.0 - initial release
//  Ports       : clk16x        - 16x bit clock
//                reset         - synchronous active-high reset
//                nrz_data      - decoded bit, valid with center_sample
//                center_sample - one-cycle strobe per received bit
//                idle_line     - carrier gone
//                mii_rx_clk    - nibble clock to MAC
//                mii_rxd[3:0]  - receive nibble
//                mii_rx_dv     - data valid
//                mii_rx_er     - receive error (oversize frame)
//                mii_crs       - carrier sense
//                sfd_timeout   - pulse: preamble ran too long without SFD
//                rx_packet_end - pulse: dv deasserted at end of frame
//                align_err     - pulse: frame ended on a partial byte
// ============================================================================
module manch_rx_mii_framer
  import manch_rx_pkg::*;
#(
  parameter int unsigned BIT_CLKS          = 16,
  parameter int unsigned MIN_PREAMBLE_BITS = 16,
  parameter int unsigned SFD_TIMEOUT_BITS  = 128,
  parameter int unsigned MAX_FRAME_BYTES   = 1536
) (
  input  logic       clk16x,
  input  logic       reset,
  input  logic       nrz_data,
  input  logic       center_sample,
  input  logic       idle_line,
  output logic       mii_rx_clk,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       mii_crs,
  output logic       sfd_timeout,
  output logic       rx_packet_end,
  output logic       align_err
);

  localparam int unsigned PW = cnt_width(MIN_PREAMBLE_BITS);
  localparam int unsigned TW = cnt_width(SFD_TIMEOUT_BITS);
  localparam int unsigned BW = cnt_width(MAX_FRAME_BYTES + 1);

  rx_state_t      state, state_n;
  logic [7:0]     sr, sr_n;
  logic [7:0]     hold, hold_n;
  logic [PW-1:0]  pcnt, pcnt_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic [2:0]     bcnt, bcnt_n;
  logic [BW-1:0]  byte_cnt, byte_cnt_n;
  logic           rem, rem_n;        // upper nibble of hold still owed in FLUSH
  logic [3:0]     rxd_n;
  logic           dv_n, er_n, crs_n, tmo_n, align_n, pend_n;
  logic           sync_zero;
  logic           nu;

  mii_rx_clkgen #(
    .BIT_CLKS (BIT_CLKS)
  ) u_clkgen (
    .clk       (clk16x),
    .rst       (reset),
    .sync_zero (sync_zero),
    .use_sync  (state == DATA),
    .rx_clk    (mii_rx_clk),
    .nu        (nu)
  );

  always_comb begin
    state_n    = state;
    sr_n       = sr;
    hold_n     = hold;
    pcnt_n     = pcnt;
    tcnt_n     = tcnt;
    bcnt_n     = bcnt;
    byte_cnt_n = byte_cnt;
    rem_n      = rem;
    rxd_n      = mii_rxd;
    dv_n       = mii_rx_dv;
    er_n       = mii_rx_er;
    crs_n      = mii_crs;
    tmo_n      = 1'b0;
    align_n    = 1'b0;
    pend_n     = 1'b0;
    sync_zero  = 1'b0;

    if (center_sample) sr_n = {nrz_data, sr[7:1]};

    case (state)
      IDLE: begin
        crs_n = 1'b0;
        if (center_sample && !idle_line) begin
          state_n = PREAMBLE;
          crs_n   = 1'b1;
          pcnt_n  = PW'(1);
          tcnt_n  = TW'(1);
        end
      end

      PREAMBLE: begin
        if (center_sample) begin
          if (tcnt != TW'(SFD_TIMEOUT_BITS)) tcnt_n = tcnt + TW'(1);
          if (nrz_data == sr[7]) begin
            // Two equal bits: "11" after a long enough run is the SFD tail,
            // anything else breaks the run and the hunt starts over.
            if (sr[7] && (pcnt >= PW'(MIN_PREAMBLE_BITS))) begin
              state_n    = DATA;
              hold_n     = SFD_BYTE;
              sync_zero  = 1'b1;
              rxd_n      = SFD_BYTE[3:0];
              dv_n       = 1'b1;
              er_n       = 1'b0;
              bcnt_n     = 3'd0;
              byte_cnt_n = '0;
            end else begin
              pcnt_n = '0;
            end
          end else if (pcnt != PW'(MIN_PREAMBLE_BITS)) begin
            pcnt_n = pcnt + PW'(1);
          end
          if ((state_n == PREAMBLE) && (tcnt_n == TW'(SFD_TIMEOUT_BITS))) begin
            tmo_n   = 1'b1;
            state_n = DROP;
          end
        end
        if (idle_line) begin
          if (state_n == DATA) begin
            state_n = FLUSH;
            rem_n   = 1'b1;
          end else begin
            state_n = IDLE;
            crs_n   = 1'b0;
          end
        end
      end

      DROP: begin
        dv_n = 1'b0;
        if (idle_line) begin
          state_n = IDLE;
          crs_n   = 1'b0;
        end
      end

      DATA: begin
        if (center_sample) begin
          bcnt_n = bcnt + 3'd1;
          if (bcnt[1:0] == 2'd3) sync_zero = 1'b1;
          // The output runs one byte behind: the upper nibble of the previous
          // byte goes out mid-byte, the lower nibble of the new byte at its end.
          if (bcnt == 3'd3) rxd_n = hold[7:4];
          if (bcnt == 3'd7) begin
            hold_n = sr_n;
            rxd_n  = sr_n[3:0];
            if (byte_cnt != BW'(MAX_FRAME_BYTES + 1)) byte_cnt_n = byte_cnt + BW'(1);
            if (byte_cnt_n > BW'(MAX_FRAME_BYTES)) er_n = 1'b1;
          end
        end
        if (idle_line) begin
          state_n = FLUSH;
          rem_n   = ~bcnt_n[2];
          if (bcnt_n != 3'd0) align_n = 1'b1;
          bcnt_n  = 3'd0;
        end
      end

      FLUSH: begin
        if (nu) begin
          if (rem) begin
            rxd_n = hold[7:4];
            rem_n = 1'b0;
          end else begin
            dv_n    = 1'b0;
            er_n    = 1'b0;
            crs_n   = 1'b0;
            pend_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk16x) begin
    if (reset) begin
      state         <= IDLE;
      sr            <= '0;
      hold          <= '0;
      pcnt          <= '0;
      tcnt          <= '0;
      bcnt          <= '0;
      byte_cnt      <= '0;
      rem           <= 1'b0;
      mii_rxd       <= '0;
      mii_rx_dv     <= 1'b0;
      mii_rx_er     <= 1'b0;
      mii_crs       <= 1'b0;
      sfd_timeout   <= 1'b0;
      align_err     <= 1'b0;
      rx_packet_end <= 1'b0;
    end else begin
      state         <= state_n;
      sr            <= sr_n;
      hold          <= hold_n;
      pcnt          <= pcnt_n;
      tcnt          <= tcnt_n;
      bcnt          <= bcnt_n;
      byte_cnt      <= byte_cnt_n;
      rem           <= rem_n;
      mii_rxd       <= rxd_n;
      mii_rx_dv     <= dv_n;
      mii_rx_er     <= er_n;
      mii_crs       <= crs_n;
      sfd_timeout   <= tmo_n;
      align_err     <= align_n;
      rx_packet_end <= pend_n;
    end
  end

endmodule
`default_nettype wire
